// File: rtl/lcd_digit_reader.sv
// HD44780 single-character DDRAM reader: one timed read cycle, ASCII digit decode, ready/valid result.
// Optional busy-flag polling before the data read is enabled by defining LCD_READER_BUSY_POLL_EN.
module lcd_digit_reader #(
  parameter int SETUP_CYCLES  = 2,
  parameter int E_HIGH_CYCLES = 12,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  input  logic [7:0] lcdDataIn,
  output logic       lcdRs,
  output logic       lcdRw,
  output logic       lcdE,
  output logic [3:0] bcdOut,
  output logic       digitError,
  output logic       outValid,
  input  logic       outReady
);

  localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_SH > E_HIGH_CYCLES) ? MAX_SH : E_HIGH_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_EHIGH = CNT_W'(E_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_ZERO  = CNT_W'(0);

`ifdef LCD_READER_BUSY_POLL_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_EHIGH  = 3'd2,
    S_HOLD   = 3'd3,
    S_OUT    = 3'd4,
    S_BSETUP = 3'd5,
    S_BEHIGH = 3'd6,
    S_BHOLD  = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EHIGH = 3'd2,
    S_HOLD  = 3'd3,
    S_OUT   = 3'd4
  } state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_data;
  logic             r_busy;
  logic             r_rs;
  logic             r_rw;
  logic             r_e;
  logic [3:0]       r_bcd;
  logic             r_err;
  logic             r_valid;
  logic [4:0]       w_decoded;

  // Returns {error, bcd}: ASCII '0'..'9' map to their low nibble, anything else to error/F.
  function automatic logic [4:0] decode_digit(input logic [7:0] ch);
    logic [4:0] res;
    if ((ch >= 8'h30) && (ch <= 8'h39)) begin
      res = {1'b0, ch[3:0]};
    end else begin
      res = {1'b1, 4'hF};
    end
    return res;
  endfunction

  assign w_decoded = decode_digit(r_data);

  // Read-cycle sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= L_ZERO;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
      r_rs    <= 1'b0;
      r_rw    <= 1'b0;
      r_e     <= 1'b0;
      r_bcd   <= 4'h0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_rw   <= 1'b1;
            r_cnt  <= L_SETUP;
`ifdef LCD_READER_BUSY_POLL_EN
            r_state <= S_BSETUP;
            r_rs    <= 1'b0;
`else
            r_state <= S_SETUP;
            r_rs    <= 1'b1;
`endif
          end
        end
`ifdef LCD_READER_BUSY_POLL_EN
        S_BSETUP: begin
          if (r_cnt == L_ZERO) begin
            r_state <= S_BEHIGH;
            r_e     <= 1'b1;
            r_cnt   <= L_EHIGH;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_BEHIGH: begin
          if (r_cnt == L_ZERO) begin
            r_state <= S_BHOLD;
            r_e     <= 1'b0;
            r_data  <= lcdDataIn;
            r_cnt   <= L_HOLD;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_BHOLD: begin
          // Bit 7 of the status byte is the controller's busy flag; keep polling while set.
          if (r_cnt == L_ZERO) begin
            r_cnt <= L_SETUP;
            if (r_data[7]) begin
              r_state <= S_BSETUP;
            end else begin
              r_state <= S_SETUP;
              r_rs    <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
`endif
        S_SETUP: begin
          if (r_cnt == L_ZERO) begin
            r_state <= S_EHIGH;
            r_e     <= 1'b1;
            r_cnt   <= L_EHIGH;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_EHIGH: begin
          if (r_cnt == L_ZERO) begin
            r_state <= S_HOLD;
            r_e     <= 1'b0;
            r_data  <= lcdDataIn;
            r_cnt   <= L_HOLD;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_HOLD: begin
          if (r_cnt == L_ZERO) begin
            r_state <= S_OUT;
            r_rs    <= 1'b0;
            r_rw    <= 1'b0;
            r_valid <= 1'b1;
            r_bcd   <= w_decoded[3:0];
            r_err   <= w_decoded[4];
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_OUT: begin
          if (outReady) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= L_ZERO;
          r_busy  <= 1'b0;
          r_rs    <= 1'b0;
          r_rw    <= 1'b0;
          r_e     <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign lcdRs      = r_rs;
  assign lcdRw      = r_rw;
  assign lcdE       = r_e;
  assign bcdOut     = r_bcd;
  assign digitError = r_err;
  assign outValid   = r_valid;

endmodule

// File: tb/tb_lcd_digit_reader.sv
// Directed self-checking bench for lcd_digit_reader with default timing parameters.
module tb_lcd_digit_reader;

`ifdef LCD_READER_BUSY_POLL_EN
  localparam int LAT   = 32;
  localparam int E_EXP = 24;
`else
  localparam int LAT   = 16;
  localparam int E_EXP = 12;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic [7:0] lcdDataIn;
  logic       lcdRs;
  logic       lcdRw;
  logic       lcdE;
  logic [3:0] bcdOut;
  logic       digitError;
  logic       outValid;
  logic       outReady;

  int checks = 0;
  int errors = 0;

  lcd_digit_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .lcdDataIn  (lcdDataIn),
    .lcdRs      (lcdRs),
    .lcdRw      (lcdRw),
    .lcdE       (lcdE),
    .bcdOut     (bcdOut),
    .digitError (digitError),
    .outValid   (outValid),
    .outReady   (outReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read with outReady=1; data switches d0->d1 on the cycle after the data-read E falls.
  task automatic run_read(input logic [7:0] d0, input logic [7:0] d1,
                          output int e_cyc, output int v_at, output int v_cnt,
                          output logic [3:0] bcd, output logic err);
    logic prev_e;
    prev_e = 1'b0;
    e_cyc = 0; v_at = -1; v_cnt = 0; bcd = 4'bxxxx; err = 1'bx;
    lcdDataIn = d0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (lcdE) e_cyc++;
      if (prev_e && !lcdE && lcdRs) lcdDataIn = d1;
      if (outValid) begin
        v_cnt++;
        if (v_at < 0) begin
          v_at = n; bcd = bcdOut; err = digitError;
        end
      end
      prev_e = lcdE;
      @(negedge clk);
    end
  endtask

  initial begin
    int e_cyc, v_at, v_cnt, w, nvalid;
    logic [3:0] bcd;
    logic err;
    reset = 1'b1; start = 1'b0; outReady = 1'b1; lcdDataIn = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rs", lcdRs, 1'b0);
    check("rst_rw", lcdRw, 1'b0);
    check("rst_e", lcdE, 1'b0);
    check("rst_valid", outValid, 1'b0);
    check("rst_bcd", bcdOut, 4'h0);
    check("rst_err", digitError, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // Basic read of '7'
    run_read(8'h37, 8'h37, e_cyc, v_at, v_cnt, bcd, err);
    check("basic_e_cycles", e_cyc, E_EXP);
    check("basic_latency", v_at, LAT);
    check("basic_valid_cnt", v_cnt, 1);
    check("basic_bcd", bcd, 4'h7);
    check("basic_err", err, 1'b0);
    check("basic_idle_busy", busy, 1'b0);
    check("basic_bcd_held", bcdOut, 4'h7);

    run_read(8'h45, 8'h45, e_cyc, v_at, v_cnt, bcd, err);
    check("dec45_bcd", bcd, 4'hF);
    check("dec45_err", err, 1'b1);
    run_read(8'h3A, 8'h3A, e_cyc, v_at, v_cnt, bcd, err);
    check("dec3a_bcd", bcd, 4'hF);
    check("dec3a_err", err, 1'b1);
    run_read(8'h2F, 8'h2F, e_cyc, v_at, v_cnt, bcd, err);
    check("dec2f_bcd", bcd, 4'hF);
    check("dec2f_err", err, 1'b1);
    run_read(8'h30, 8'h30, e_cyc, v_at, v_cnt, bcd, err);
    check("dec30_bcd", bcd, 4'h0);
    check("dec30_err", err, 1'b0);
    run_read(8'h39, 8'h39, e_cyc, v_at, v_cnt, bcd, err);
    check("dec39_bcd", bcd, 4'h9);
    check("dec39_err", err, 1'b0);

    // Data changes right after E falls; the byte present at the fall must be kept
    run_read(8'h31, 8'h32, e_cyc, v_at, v_cnt, bcd, err);
    check("capture_bcd", bcd, 4'h1);

    // Backpressure
    outReady = 1'b0;
    lcdDataIn = 8'h34;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bp_busy_start", busy, 1'b1);
    check("bp_rs_start", lcdRs, 1'b1);
    w = 0;
    while (!outValid && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("bp_valid_reached", outValid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", outValid, 1'b1);
      check("bp_bcd_hold", bcdOut, 4'h4);
      check("bp_busy_hold", busy, 1'b1);
      start = ((i % 2) == 0);
      @(negedge clk);
    end
    outReady = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bp_release_valid", outValid, 1'b0);
    check("bp_release_busy", busy, 1'b0);
    check("bp_release_bcd", bcdOut, 4'h4);
    @(negedge clk);
    check("bp_no_queue", busy, 1'b0);

    // Reset in the middle of the E pulse
    lcdDataIn = 8'h38;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!lcdE && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("mid_e_reached", lcdE, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_e", lcdE, 1'b0);
    check("mid_rst_rs", lcdRs, 1'b0);
    check("mid_rst_rw", lcdRw, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_bcd", bcdOut, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      if (outValid || busy) nvalid++;
      @(negedge clk);
    end
    check("mid_rst_no_valid", nvalid, 0);

    // Start on the first edge after reset release
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_start", busy, 1'b1);
    w = 0;
    while (!outValid && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("post_rst_valid", outValid, 1'b1);
    check("post_rst_bcd", bcdOut, 4'h8);
    @(negedge clk);
    check("post_rst_idle", busy, 1'b0);

`ifdef LCD_READER_BUSY_POLL_EN
    begin
      int busy_reads, data_reads, polls_done;
      logic prev_e;
      busy_reads = 0; data_reads = 0; polls_done = 0; prev_e = 1'b0; bcd = 4'bxxxx;
      lcdDataIn = 8'h80;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 120; n++) begin
        if (lcdE && !prev_e) begin
          if (lcdRs) data_reads++;
          else busy_reads++;
        end
        if (prev_e && !lcdE && !lcdRs) begin
          polls_done++;
          if (polls_done == 2) lcdDataIn = 8'h36;
        end
        if (outValid) bcd = bcdOut;
        prev_e = lcdE;
        @(negedge clk);
      end
      check("poll_busy_reads", busy_reads, 3);
      check("poll_data_reads", data_reads, 1);
      check("poll_bcd", bcd, 4'h6);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_digit_reader.md
LCD_DIGIT_READER -- requirements
Module: lcd_digit_reader

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2: cycles RS/RW are held before E rises (>=1).
REQ-002 SHALL have parameter E_HIGH_CYCLES, default 12: cycles E is held high (>=2).
REQ-003 SHALL have parameter HOLD_CYCLES, default 2: cycles E is held low after the fall, before the result is presented (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request one DDRAM character read; sampled only in IDLE.
REQ-007 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-008 SHALL have port lcdDataIn  input  8  HD44780 data bus, read direction.
REQ-009 SHALL have ports lcdRs, lcdRw, lcdE  output  1 each  HD44780 control lines.
REQ-010 SHALL have port bcdOut  output  4  decoded digit.
REQ-011 SHALL have port digitError  output  1  captured character was not ASCII '0'..'9'.
REQ-012 SHALL have port outValid  output  1  bcdOut/digitError are valid.
REQ-013 SHALL have port outReady  input  1  consumer accepts the result.

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> EHIGH -> HOLD -> OUT -> IDLE, using one down-counter wide enough for the largest parameter.
REQ-015 SHALL leave IDLE for SETUP on the edge where start=1; start in any other state SHALL be ignored (not queued).
REQ-016 SHALL drive lcdRs=1 and lcdRw=1 in SETUP, EHIGH and HOLD, and lcdRs=0, lcdRw=0 in IDLE and OUT.
REQ-017 SHALL drive lcdE=1 only in EHIGH, for exactly E_HIGH_CYCLES cycles.
REQ-018 SHALL stay SETUP_CYCLES cycles in SETUP and HOLD_CYCLES cycles in HOLD.
REQ-019 SHALL register lcdDataIn on the last EHIGH cycle (the edge on which E falls).
REQ-020 SHALL decode captured bytes 8'h30..8'h39 to bcdOut = low nibble with digitError=0.
REQ-021 SHALL decode any other byte, including 8'h45 'E', to bcdOut=4'hF with digitError=1.
REQ-022 SHALL assert outValid only in OUT, holding bcdOut/digitError stable until the edge where outValid=1 and outReady=1, then return to IDLE.
REQ-023 SHALL time latency so that outValid first rises SETUP_CYCLES+E_HIGH_CYCLES+HOLD_CYCLES cycles after the edge that samples start.
REQ-024 SHALL accept a start asserted in the same cycle as the OUT handshake only on a later IDLE cycle, since busy=1 during OUT.
REQ-025 SHALL hold bcdOut/digitError at their last values outside OUT; they are not qualified there.

Reset
REQ-026 SHALL, on reset=1 at any time including mid-read, enter IDLE immediately without waiting for a clock edge.
REQ-027 SHALL reset outputs to busy=0, lcdRs=0, lcdRw=0, lcdE=0, outValid=0, bcdOut=4'h0, digitError=0, with the counter at 0.
REQ-028 SHALL, on the first edge after reset release, sample start as in IDLE.

Configuration
REQ-029 SHALL, with macro LCD_READER_BUSY_POLL_EN defined, insert states BSETUP/BEHIGH/BHOLD before SETUP that perform a busy-flag read (lcdRs=0, lcdRw=1), using the same three timings.
REQ-030 SHALL, with LCD_READER_BUSY_POLL_EN defined, repeat the busy-flag read while captured bit 7 = 1, and enter SETUP once bit 7 = 0.
REQ-031 SHALL, without LCD_READER_BUSY_POLL_EN, omit the busy-read states and behave exactly per REQ-014..REQ-025.

Verification
REQ-032 SHALL verify a basic read: defaults, lcdDataIn=8'h37, start pulse, outReady=1 -> lcdE high 12 cycles; outValid high 16 cycles after start edge for 1 cycle; bcdOut=4'h7, digitError=0.
REQ-033 SHALL verify error decoding: lcdDataIn=8'h45 -> bcdOut=4'hF, digitError=1; lcdDataIn=8'h3A -> bcdOut=4'hF, digitError=1.
REQ-034 SHALL verify backpressure: outReady=0 for 5 cycles after outValid -> outValid and bcdOut held 5 cycles; busy=1; start pulses ignored; IDLE one cycle after outReady=1.
REQ-035 SHALL verify capture timing: lcdDataIn changes 8'h31 -> 8'h32 on the cycle after E falls -> bcdOut=4'h1.
REQ-036 SHALL verify reset mid-read: reset asserted during EHIGH -> lcdE, lcdRs, lcdRw, busy go 0 before the next edge; no outValid occurs.
REQ-037 SHALL verify busy polling: with LCD_READER_BUSY_POLL_EN, bit 7 = 1 on 2 polls then 0 -> exactly 3 busy reads with lcdRs=0 precede one data read.
